// File: rtl/mem_fetch_pkg.sv
// Shared types and constants for the instruction-cache line fetcher.
package mem_fetch_pkg;

  localparam int LINE_WORDS  = 4;
  localparam int OFFSET_W    = 2;
  localparam int LINE_ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_line_fetch_line_assembler.sv
// Line buffer for mem_line_fetch: four 32-bit word registers, one written per
// accepted memory beat at the slot picked by word_idx_i.
module line_assembler
  import mem_fetch_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en_i,
  input  logic [OFFSET_W-1:0]          word_idx_i,
  input  logic [WORD_W-1:0]            wdata_i,
  output logic [LINE_WORDS*WORD_W-1:0] line_o
);

  logic [WORD_W-1:0] word_q [LINE_WORDS];

  for (genvar k = 0; k < LINE_WORDS; k++) begin : g_word
    // Untouched words keep their old contents between fills.
    always_ff @(posedge clk) begin
      if (reset) begin
        word_q[k] <= '0;
      end else if (wr_en_i && (word_idx_i == OFFSET_W'(k))) begin
        word_q[k] <= wdata_i;
      end
    end

    assign line_o[k*WORD_W +: WORD_W] = word_q[k];
  end

endmodule

// File: rtl/mem_line_fetch.sv
// Instruction-cache line-fill engine: fetches four words of a missing line.
// Define FETCH_CRITICAL_FIRST_EN to start at the missed word and wrap.
module mem_line_fetch
  import mem_fetch_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_ready,
  output logic [32*LINE_WORDS-1:0] data_line,
  output logic [ADDR_W-5:0]        line_addr,
  output logic                     line_valid,
  output logic                     busy,
  output state_e                   dbg_state
);

  // Memory handshake: a word transfers on every edge where mem_rd and
  // mem_ready are both 1; mem_rd holds and mem_addr stays put until then.

  state_e                state_q;
  logic [OFFSET_W-1:0]   word_idx_q;
  logic [OFFSET_W-1:0]   word_idx_d;
  logic [OFFSET_W-1:0]   cnt_q;
  logic [OFFSET_W-1:0]   start_off_d;
  logic [ADDR_W-5:0]     line_addr_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic                  mem_rd_q;
  logic                  busy_q;
  logic                  line_valid_q;
  logic                  beat;
  logic [3:0]            unused_req_bits;

`ifdef FETCH_CRITICAL_FIRST_EN
  assign start_off_d = req_addr[3:2];
`else
  assign start_off_d = '0;
`endif
  assign unused_req_bits = req_addr[3:0];

  assign word_idx_d = word_idx_q + OFFSET_W'(1);
  assign beat       = mem_rd_q && mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      word_idx_q   <= '0;
      cnt_q        <= '0;
      line_addr_q  <= '0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      busy_q       <= 1'b0;
      line_valid_q <= 1'b0;
    end else begin
      line_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            line_addr_q <= req_addr[ADDR_W-1:4];
            word_idx_q  <= start_off_d;
            cnt_q       <= '0;
            mem_addr_q  <= {req_addr[ADDR_W-1:4], start_off_d, 2'b00};
            mem_rd_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          if (mem_ready) begin
            word_idx_q <= word_idx_d;
            cnt_q      <= cnt_q + OFFSET_W'(1);
            mem_addr_q <= {line_addr_q, word_idx_d, 2'b00};
            if (cnt_q == OFFSET_W'(LINE_WORDS - 1)) begin
              mem_rd_q     <= 1'b0;
              busy_q       <= 1'b0;
              line_valid_q <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  line_assembler #(.WORD_W(32)) u_line_assembler (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (beat),
    .word_idx_i (word_idx_q),
    .wdata_i    (mem_rdata),
    .line_o     (data_line)
  );

  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign line_addr  = line_addr_q;
  assign line_valid = line_valid_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule
